// File: rtl/reaction_timer_nch.sv
// -----------------------------------------------------------------------------
// reaction_timer_nch
//   N-player reaction-timer core. Generates a 1 ms tick and a pseudo-random
//   foreperiod, raises GO, arbitrates the first response (lowest index wins
//   ties), latches winner and reaction time, flags false starts per player and
//   handles a no-response timeout.
//
// Optional feature: define REACTION_BEST_TRACK_EN to keep a session-best time
//   (best_ms / best_id). Undefined: best_ms is all ones, best_id is 0 and no
//   best-time registers exist.
//
// Ports:
//   clk          in   system clock
//   reset_btn_n  in   asynchronous active-low reset
//   start_btn    in   start / acknowledge level (synchronised)
//   resp_btn     in   [NUM_PLAYERS] response levels (synchronised)
//   state        out  [3] IDLE=0 WAIT=1 SIGNAL=2 RESULT=3 FALSE=4 TIMEOUT=5
//   ms_tick      out  one-cycle pulse every CLOCK_FREQ/1000 cycles
//   go           out  high while in SIGNAL
//   done         out  one-cycle pulse following entry to RESULT/FALSE/TIMEOUT
//   winner_id    out  index of the winning player
//   react_ms     out  [TIME_W] latched reaction time
//   false_mask   out  [NUM_PLAYERS] players who pressed during WAIT/FALSE
//   best_ms      out  [TIME_W] session best time
//   best_id      out  player holding the best time
// -----------------------------------------------------------------------------
module reaction_timer_nch #(
    parameter int          CLOCK_FREQ  = 50000000,
    parameter int          NUM_PLAYERS = 4,
    parameter int          TIME_W      = 14,
    parameter int          MIN_WAIT    = 500,
    parameter int          MAX_WAIT    = 2000,
    parameter int          TIMEOUT_MS  = 3000,
    parameter int          FALSE_MS    = 2000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         WID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_btn_n,
    input  logic                   start_btn,
    input  logic [NUM_PLAYERS-1:0] resp_btn,
    output logic [2:0]             state,
    output logic                   ms_tick,
    output logic                   go,
    output logic                   done,
    output logic [WID_W-1:0]       winner_id,
    output logic [TIME_W-1:0]      react_ms,
    output logic [NUM_PLAYERS-1:0] false_mask,
    output logic [TIME_W-1:0]      best_ms,
    output logic [WID_W-1:0]       best_id
);

    localparam int MS_TICKS = CLOCK_FREQ / 1000;
    localparam int TK_W     = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam int MAXV1    = (MAX_WAIT > TIMEOUT_MS) ? MAX_WAIT : TIMEOUT_MS;
    localparam int MAXV     = (MAXV1 > FALSE_MS) ? MAXV1 : FALSE_MS;
    // Internal ms counters only need to reach the largest compare value.
    localparam int CW       = $clog2(MAXV + 2);
    localparam int RANGE    = MAX_WAIT - MIN_WAIT + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_SIGNAL  = 3'd2,
        S_RESULT  = 3'd3,
        S_FALSE   = 3'd4,
        S_TIMEOUT = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [TK_W-1:0]        tick_cnt_q;
    logic                   ms_tick_q;
    logic [15:0]            lfsr_q;
    logic                   start_q;
    logic [NUM_PLAYERS-1:0] resp_q;
    logic [CW-1:0]          wait_tgt_q, wait_tgt_d;
    logic [CW-1:0]          wait_ms_q, wait_ms_d;
    logic [CW-1:0]          react_cnt_q, react_cnt_d;
    logic [CW-1:0]          false_ms_q, false_ms_d;
    logic [NUM_PLAYERS-1:0] false_mask_q, false_mask_d;
    logic [WID_W-1:0]       winner_q, winner_d;
    logic [TIME_W-1:0]      react_q, react_d;
    logic                   entry_q, entry_d;   // terminal-state entry, delays done by one
    logic                   done_q;
    logic                   go_q;

    logic                   start_rise;
    logic [NUM_PLAYERS-1:0] resp_rise;
    logic [WID_W-1:0]       win_idx;

    assign start_rise = start_btn & ~start_q;
    assign resp_rise  = resp_btn & ~resp_q;

    // Lowest set index wins: scan high-to-low so the lowest overwrites last.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (resp_rise[i]) win_idx = WID_W'(i);
        end
    end

    // Tick generator, LFSR and edge-detect registers run in every state.
    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            tick_cnt_q <= '0;
            ms_tick_q  <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            start_q    <= 1'b0;
            resp_q     <= '0;
        end else begin
            ms_tick_q  <= (tick_cnt_q == TK_W'(MS_TICKS - 1));
            tick_cnt_q <= (tick_cnt_q == TK_W'(MS_TICKS - 1)) ? '0 : tick_cnt_q + 1'b1;
            lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            start_q    <= start_btn;
            resp_q     <= resp_btn;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_tgt_d   = wait_tgt_q;
        wait_ms_d    = wait_ms_q;
        react_cnt_d  = react_cnt_q;
        false_ms_d   = false_ms_q;
        false_mask_d = false_mask_q;
        winner_d     = winner_q;
        react_d      = react_q;
        entry_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d      = S_WAIT;
                    wait_tgt_d   = CW'(MIN_WAIT) + CW'(32'(lfsr_q) % 32'(RANGE));
                    wait_ms_d    = '0;
                    react_cnt_d  = '0;
                    false_ms_d   = '0;
                    false_mask_d = '0;
                end
            end
            S_WAIT: begin
                if (ms_tick_q) wait_ms_d = wait_ms_q + 1'b1;
                // A press beats an expiring foreperiod in the same cycle.
                if (|resp_rise) begin
                    false_mask_d = resp_rise;
                    state_d      = S_FALSE;
                    entry_d      = 1'b1;
                end else if (wait_ms_q >= wait_tgt_q) begin
                    state_d = S_SIGNAL;
                end
            end
            S_SIGNAL: begin
                if (ms_tick_q) react_cnt_d = react_cnt_q + 1'b1;
                if (|resp_rise) begin
                    winner_d = win_idx;
                    react_d  = TIME_W'(react_cnt_q);
                    state_d  = S_RESULT;
                    entry_d  = 1'b1;
                end else if (react_cnt_q >= CW'(TIMEOUT_MS)) begin
                    react_d = TIME_W'(TIMEOUT_MS);
                    state_d = S_TIMEOUT;
                    entry_d = 1'b1;
                end
            end
            S_RESULT, S_TIMEOUT: begin
                if (start_rise) state_d = S_IDLE;
            end
            S_FALSE: begin
                if (ms_tick_q) false_ms_d = false_ms_q + 1'b1;
                false_mask_d = false_mask_q | resp_rise;
                if (false_ms_q >= CW'(FALSE_MS)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;  // encodings 6/7 recover
        endcase
    end

    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            state_q      <= S_IDLE;
            wait_tgt_q   <= '0;
            wait_ms_q    <= '0;
            react_cnt_q  <= '0;
            false_ms_q   <= '0;
            false_mask_q <= '0;
            winner_q     <= '0;
            react_q      <= '0;
            entry_q      <= 1'b0;
            done_q       <= 1'b0;
            go_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_tgt_q   <= wait_tgt_d;
            wait_ms_q    <= wait_ms_d;
            react_cnt_q  <= react_cnt_d;
            false_ms_q   <= false_ms_d;
            false_mask_q <= false_mask_d;
            winner_q     <= winner_d;
            react_q      <= react_d;
            entry_q      <= entry_d;
            done_q       <= entry_q;
            go_q         <= (state_d == S_SIGNAL);
        end
    end

`ifdef REACTION_BEST_TRACK_EN
    logic [TIME_W-1:0] best_ms_q;
    logic [WID_W-1:0]  best_id_q;

    // Strict less-than: a tie leaves the earlier holder in place.
    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            best_ms_q <= '1;
            best_id_q <= '0;
        end else if (state_q == S_SIGNAL && state_d == S_RESULT && react_d < best_ms_q) begin
            best_ms_q <= react_d;
            best_id_q <= winner_d;
        end
    end

    assign best_ms = best_ms_q;
    assign best_id = best_id_q;
`else
    assign best_ms = '1;
    assign best_id = '0;
`endif

    assign state      = state_q;
    assign ms_tick    = ms_tick_q;
    assign go         = go_q;
    assign done       = done_q;
    assign winner_id  = winner_q;
    assign react_ms   = react_q;
    assign false_mask = false_mask_q;

endmodule

// File: tb/tb_reaction_timer_nch.sv
module tb_reaction_timer_nch;

    logic        clk;
    logic        reset_btn_n;
    logic        start_btn;
    logic [3:0]  resp_btn;
    logic [2:0]  state;
    logic        ms_tick;
    logic        go;
    logic        done;
    logic [1:0]  winner_id;
    logic [13:0] react_ms;
    logic [3:0]  false_mask;
    logic [13:0] best_ms;
    logic [1:0]  best_id;

    int vectors = 0;
    int errs    = 0;

    reaction_timer_nch #(
        .CLOCK_FREQ (10000),
        .NUM_PLAYERS(4),
        .TIME_W     (14),
        .MIN_WAIT   (5),
        .MAX_WAIT   (20),
        .TIMEOUT_MS (30),
        .FALSE_MS   (10),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk        (clk),
        .reset_btn_n(reset_btn_n),
        .start_btn  (start_btn),
        .resp_btn   (resp_btn),
        .state      (state),
        .ms_tick    (ms_tick),
        .go         (go),
        .done       (done),
        .winner_id  (winner_id),
        .react_ms   (react_ms),
        .false_mask (false_mask),
        .best_ms    (best_ms),
        .best_id    (best_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    // Bounded wait on state; expiry is a miscompare.
    task automatic wait_state(input logic [2:0] s, input int max, input string name, output int cyc);
        cyc = 0;
        while (state !== s && cyc < max) begin
            step();
            cyc++;
        end
        vectors++;
        if (state !== s) begin
            errs++;
            $display("FAIL %s: state=%0d want %0d after %0d cycles", name, state, s, cyc);
        end
    endtask

    // From the first SIGNAL cycle: press so that exactly n ticks have been counted.
    task automatic press_after(input int n, input logic [3:0] mask);
        int seen = 0;
        int guard = 0;
        while (seen < n && guard < 2000) begin
            if (ms_tick) seen++;
            step();
            guard++;
        end
        resp_btn = mask;
        step();
    endtask

    task automatic apply_reset();
        reset_btn_n = 1'b0;
        start_btn   = 1'b0;
        resp_btn    = 4'b0;
        repeat (3) step();
        reset_btn_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_btn_n = 1'b0;
        start_btn   = 1'b0;
        resp_btn    = 4'b0;
        repeat (3) step();
        vectors++;
        if (state !== 3'd0 || ms_tick !== 1'b0 || go !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctrl: state=%0d tick=%0b go=%0b done=%0b want 0 0 0 0", state, ms_tick, go, done);
        end
        vectors++;
        if (winner_id !== 2'd0 || react_ms !== 14'd0 || false_mask !== 4'd0) begin
            errs++;
            $display("FAIL reset_latch: win=%0d react=%0d mask=%b want 0 0 0000", winner_id, react_ms, false_mask);
        end
        vectors++;
        if (best_ms !== 14'h3FFF || best_id !== 2'd0 || dut.lfsr_q !== 16'hACE1) begin
            errs++;
            $display("FAIL reset_best: best=%h id=%0d lfsr=%h want 3fff 0 ace1", best_ms, best_id, dut.lfsr_q);
        end
        reset_btn_n = 1'b1;
        step();
    endtask

    task automatic test_normal();
        int cyc;
        press_start();
        vectors++;
        if (state !== 3'd1) begin errs++; $display("FAIL normal_wait: state=%0d want 1", state); end
        wait_state(3'd2, 260, "normal_signal", cyc);
        vectors++;
        if (cyc < 40 || cyc > 215) begin
            errs++;
            $display("FAIL normal_foreperiod: %0d cycles want 40..215", cyc);
        end
        vectors++;
        if (go !== 1'b1) begin errs++; $display("FAIL normal_go_high: go=%0b want 1", go); end
        press_after(7, 4'b0100);
        vectors++;
        if (state !== 3'd3 || winner_id !== 2'd2 || react_ms !== 14'd7) begin
            errs++;
            $display("FAIL normal_result: state=%0d win=%0d react=%0d want 3 2 7", state, winner_id, react_ms);
        end
        vectors++;
        if (go !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL normal_entry: go=%0b done=%0b want 0 0", go, done);
        end
        resp_btn = 4'b0;
        step();
        vectors++;
        if (done !== 1'b1) begin errs++; $display("FAIL normal_done_pulse: done=%0b want 1", done); end
        step();
        vectors++;
        if (done !== 1'b0) begin errs++; $display("FAIL normal_done_end: done=%0b want 0", done); end
        resp_btn = 4'b0001;
        step();
        resp_btn = 4'b0;
        step();
        vectors++;
        if (state !== 3'd3 || winner_id !== 2'd2) begin
            errs++;
            $display("FAIL result_ignores_resp: state=%0d win=%0d want 3 2", state, winner_id);
        end
        press_start();
        vectors++;
        if (state !== 3'd0 || winner_id !== 2'd2 || react_ms !== 14'd7) begin
            errs++;
            $display("FAIL normal_idle_persist: state=%0d win=%0d react=%0d want 0 2 7", state, winner_id, react_ms);
        end
    endtask

    task automatic test_tie();
        int cyc;
        press_start();
        wait_state(3'd2, 260, "tie_signal", cyc);
        press_after(1, 4'b1010);
        vectors++;
        if (state !== 3'd3 || winner_id !== 2'd1 || react_ms !== 14'd1) begin
            errs++;
            $display("FAIL tie_winner: state=%0d win=%0d react=%0d want 3 1 1", state, winner_id, react_ms);
        end
        resp_btn = 4'b0;
        press_start();
        vectors++;
        if (state !== 3'd0) begin errs++; $display("FAIL tie_idle: state=%0d want 0", state); end
    endtask

    task automatic test_false_start();
        int cyc;
        press_start();
        repeat (2) step();
        resp_btn = 4'b0001;
        step();
        vectors++;
        if (state !== 3'd4 || false_mask !== 4'b0001 || done !== 1'b0) begin
            errs++;
            $display("FAIL false_entry: state=%0d mask=%b done=%0b want 4 0001 0", state, false_mask, done);
        end
        step();
        vectors++;
        if (done !== 1'b1) begin errs++; $display("FAIL false_done: done=%0b want 1", done); end
        repeat (18) step();
        resp_btn = 4'b1001;
        step();
        vectors++;
        if (state !== 3'd4 || false_mask !== 4'b1001) begin
            errs++;
            $display("FAIL false_or_mask: state=%0d mask=%b want 4 1001", state, false_mask);
        end
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        vectors++;
        if (state !== 3'd4) begin errs++; $display("FAIL false_start_ignored: state=%0d want 4", state); end
        wait_state(3'd0, 150, "false_to_idle", cyc);
        vectors++;
        if (cyc + 21 < 90 || cyc + 21 > 105) begin
            errs++;
            $display("FAIL false_hold_time: %0d cycles want 90..105", cyc + 21);
        end
        vectors++;
        if (false_mask !== 4'b1001) begin
            errs++;
            $display("FAIL false_mask_persist: mask=%b want 1001", false_mask);
        end
        resp_btn = 4'b0;
        step();
    endtask

    task automatic test_held_timeout();
        int cyc;
        resp_btn = 4'b0010;
        repeat (2) step();
        press_start();
        wait_state(3'd2, 260, "held_no_false", cyc);
        vectors++;
        if (go !== 1'b1) begin errs++; $display("FAIL held_go: go=%0b want 1", go); end
        wait_state(3'd5, 400, "held_timeout", cyc);
        vectors++;
        if (react_ms !== 14'd30 || winner_id !== 2'd1 || go !== 1'b0) begin
            errs++;
            $display("FAIL timeout_latch: react=%0d win=%0d go=%0b want 30 1 0", react_ms, winner_id, go);
        end
        resp_btn = 4'b0;
        press_start();
        vectors++;
        if (state !== 3'd0) begin errs++; $display("FAIL timeout_ack: state=%0d want 0", state); end
    endtask

    task automatic run_round(input int n, input logic [3:0] mask, input logic [1:0] wid);
        int cyc;
        press_start();
        wait_state(3'd2, 260, "best_round_signal", cyc);
        press_after(n, mask);
        vectors++;
        if (state !== 3'd3 || react_ms !== 14'(n) || winner_id !== wid) begin
            errs++;
            $display("FAIL best_round: state=%0d react=%0d win=%0d want 3 %0d %0d", state, react_ms, winner_id, n, wid);
        end
        resp_btn = 4'b0;
        press_start();
    endtask

    task automatic test_best();
        apply_reset();
        run_round(12, 4'b0001, 2'd0);
`ifdef REACTION_BEST_TRACK_EN
        vectors++;
        if (best_ms !== 14'd12 || best_id !== 2'd0) begin
            errs++;
            $display("FAIL best_first: best=%0d id=%0d want 12 0", best_ms, best_id);
        end
`endif
        run_round(8, 4'b0100, 2'd2);
        run_round(8, 4'b1000, 2'd3);
`ifdef REACTION_BEST_TRACK_EN
        vectors++;
        if (best_ms !== 14'd8 || best_id !== 2'd2) begin
            errs++;
            $display("FAIL best_tie_keeps: best=%0d id=%0d want 8 2", best_ms, best_id);
        end
`else
        vectors++;
        if (best_ms !== 14'h3FFF || best_id !== 2'd0) begin
            errs++;
            $display("FAIL best_disabled: best=%h id=%0d want 3fff 0", best_ms, best_id);
        end
`endif
    endtask

    task automatic test_async_reset();
        int cyc;
        press_start();
        wait_state(3'd2, 260, "areset_signal", cyc);
        repeat (3) step();
        reset_btn_n = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0 || go !== 1'b0 || done !== 1'b0 || ms_tick !== 1'b0) begin
            errs++;
            $display("FAIL areset_ctrl: state=%0d go=%0b done=%0b tick=%0b want 0 0 0 0", state, go, done, ms_tick);
        end
        vectors++;
        if (winner_id !== 2'd0 || react_ms !== 14'd0 || false_mask !== 4'd0 ||
            best_ms !== 14'h3FFF || best_id !== 2'd0 || dut.lfsr_q !== 16'hACE1) begin
            errs++;
            $display("FAIL areset_regs: win=%0d react=%0d mask=%b best=%h id=%0d lfsr=%h want 0 0 0000 3fff 0 ace1",
                     winner_id, react_ms, false_mask, best_ms, best_id, dut.lfsr_q);
        end
        @(negedge clk);
        reset_btn_n = 1'b1;
        step();
    endtask

    initial begin
        reset_btn_n = 1'b0;
        start_btn   = 1'b0;
        resp_btn    = 4'b0;
        test_reset();
        test_normal();
        test_tie();
        test_false_start();
        test_held_timeout();
        test_best();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
